// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ram_arbiter_pkg: shared state encodings and RAM control-word bit positions.
// Rev 1.0
package ram_arbiter_pkg;

  localparam logic [1:0] A_STATE_IDLE     = 2'd0;
  localparam logic [1:0] A_STATE_ISSUE    = 2'd1;
  localparam logic [1:0] A_STATE_WAIT_ACK = 2'd2;
  localparam logic [1:0] A_STATE_WAIT_REL = 2'd3;

  localparam int RAM_ACK       = 0;
  localparam int RAM_READ_PIN  = 0;
  localparam int RAM_WRITE_PIN = 1;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_grant2.sv
`default_nettype none
// rr_grant2: combinational two-way round-robin picker.
// Rev 1.0
module rr_grant2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_id,
  output logic any_valid
);

  assign any_valid = valid0 | valid1;

  // On contention the port that did not win last time is favoured.
  always_comb begin
    grant_id = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: two-port round-robin arbiter running the 4-phase RAM pin/ACK handshake.
// Rev 1.0
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  input  logic [31:0]       ram_ctrl_from_hw,
  output logic [31:0]       ram_ctrl_to_hw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_to_hw,
  input  logic [DATA_W-1:0] data_from_hw
);

  localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [CNT_W-1:0]  tcnt;
  logic              last_grant;
  logic              req_port;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic        ack;
  logic        grant_id;
  logic        any_valid;
  logic        tmo;
  logic        do_grant;
  logic        do_issue;
  logic        do_capture;
  logic        do_done;
  logic        do_err;
  logic [31:0] pin_word;
  logic        unused_ctrl;

  assign ack         = ram_ctrl_from_hw[RAM_ACK];
  assign tmo         = (tcnt == CNT_MAX);
  assign unused_ctrl = ^ram_ctrl_from_hw;

  rr_grant2 u_rr_grant2 (
    .valid0     (p0_valid),
    .valid1     (p1_valid),
    .last_grant (last_grant),
    .grant_id   (grant_id),
    .any_valid  (any_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= A_STATE_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake progress always wins over a timeout landing on the same edge.
  always_comb begin
    next_state = state;
    case (state)
      A_STATE_IDLE:     if (any_valid) next_state = A_STATE_ISSUE;
      A_STATE_ISSUE:    if (!ack) next_state = A_STATE_WAIT_ACK;
                        else if (tmo) next_state = A_STATE_IDLE;
      A_STATE_WAIT_ACK: if (ack) next_state = A_STATE_WAIT_REL;
                        else if (tmo) next_state = A_STATE_IDLE;
      A_STATE_WAIT_REL: if (!ack || tmo) next_state = A_STATE_IDLE;
      default:          next_state = A_STATE_IDLE;
    endcase
  end

  always_comb begin
    do_grant   = (state == A_STATE_IDLE) && any_valid;
    do_issue   = (state == A_STATE_ISSUE) && !ack;
    do_capture = (state == A_STATE_WAIT_ACK) && ack;
    do_done    = (state == A_STATE_WAIT_REL) && !ack;
    do_err     = tmo && (((state == A_STATE_ISSUE) && ack) ||
                         ((state == A_STATE_WAIT_ACK) && !ack) ||
                         ((state == A_STATE_WAIT_REL) && ack));
    pin_word   = '0;
    pin_word[req_we ? RAM_WRITE_PIN : RAM_READ_PIN] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if ((state == A_STATE_IDLE) || (next_state != state)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant     <= 1'b1;
      req_port       <= 1'b0;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      ram_ctrl_to_hw <= '0;
      addr           <= '0;
      data_to_hw     <= '0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_err         <= 1'b0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      if (do_grant) begin
        req_port   <= grant_id;
        req_we     <= grant_id ? p1_we    : p0_we;
        req_addr   <= grant_id ? p1_addr  : p0_addr;
        req_wdata  <= grant_id ? p1_wdata : p0_wdata;
        last_grant <= grant_id;
      end
      if (do_issue) begin
        addr           <= req_addr;
        ram_ctrl_to_hw <= pin_word;
        if (req_we) begin
          data_to_hw <= req_wdata;
        end
      end
      if (do_capture) begin
        ram_ctrl_to_hw <= '0;
        if (!req_we) begin
          if (req_port) p1_rdata <= data_from_hw;
          else          p0_rdata <= data_from_hw;
        end
      end
      if (do_done) begin
        if (req_port) p1_done <= 1'b1;
        else          p0_done <= 1'b1;
      end
      if (do_err) begin
        ram_ctrl_to_hw <= '0;
        if (req_port) p1_err <= 1'b1;
        else          p0_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: directed bench with a transaction-level arbiter/RAM model.
// Rev 1.0
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_we, p1_valid, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [31:0] ram_ctrl_from_hw, ram_ctrl_to_hw, addr, data_to_hw, data_from_hw;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
    .ram_ctrl_from_hw(ram_ctrl_from_hw), .ram_ctrl_to_hw(ram_ctrl_to_hw),
    .addr(addr), .data_to_hw(data_to_hw), .data_from_hw(data_from_hw)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
  } txn_t;

  txn_t        exp_issue[$];
  txn_t        inflight;
  logic        inflight_v = 1'b0;
  logic [31:0] inflight_rd;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_rdata [2];
  logic [31:0] model_dth = '0;
  logic [31:0] prev_pins = '0;
  logic        pin_d = 1'b0;
  logic        ack_force = 1'b0;
  logic        ack_never = 1'b0;
  int          n_cmpl = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic void push(input int p, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic e);
    txn_t t;
    t.port = p; t.we = we; t.addr = a; t.wdata = d; t.exp_err = e;
    exp_issue.push_back(t);
  endfunction

  // Compare process followed by the RAM responder (ACK trails the pins by one register stage).
  always @(negedge clk) begin
    logic [31:0] pins;
    logic        ack_now;
    int          ev_port;
    logic        ev_err;
    pins = ram_ctrl_to_hw;
    if (rst) begin
      inflight_v     = 1'b0;
      model_rdata[0] = '0;
      model_rdata[1] = '0;
      model_dth      = '0;
      prev_pins      = '0;
      pin_d          = 1'b0;
    end else begin
      chk("ctrl_legal", (pins == 32'h0) || (pins == (32'h1 << RAM_READ_PIN)) ||
                        (pins == (32'h1 << RAM_WRITE_PIN)), 1);
      if (pins != 0 && prev_pins == 0) begin
        if (exp_issue.size() == 0 || inflight_v) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          inflight = exp_issue.pop_front();
          chk("issue_we",   pins[RAM_WRITE_PIN], inflight.we);
          chk("issue_addr", addr, inflight.addr);
          chk("issue_data", data_to_hw, inflight.we ? inflight.wdata : model_dth);
          inflight_rd = mem_rd(inflight.addr);
          if (inflight.we) begin
            mem[inflight.addr] = inflight.wdata;
            model_dth          = inflight.wdata;
          end
          inflight_v = 1'b1;
        end
      end
      if (p0_done | p1_done | p0_err | p1_err) begin
        ev_port = (p1_done | p1_err) ? 1 : 0;
        ev_err  = p0_err | p1_err;
        chk("single_event", 32'(p0_done) + 32'(p1_done) + 32'(p0_err) + 32'(p1_err), 1);
        chk("event_ctrl_clear", pins, 0);
        if (!inflight_v) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          chk("event_port", ev_port, inflight.port);
          chk("event_err", ev_err, inflight.exp_err);
          if (!ev_err && !inflight.we) model_rdata[inflight.port] = inflight_rd;
          inflight_v = 1'b0;
          n_cmpl++;
        end
      end
      if (!(inflight_v && !inflight.we && inflight.port == 0)) chk("p0_rdata", p0_rdata, model_rdata[0]);
      if (!(inflight_v && !inflight.we && inflight.port == 1)) chk("p1_rdata", p1_rdata, model_rdata[1]);
      prev_pins = pins;
    end
    ack_now = ack_force ? 1'b1 : (ack_never ? 1'b0 : pin_d);
    pin_d   = rst ? 1'b0 : (pins != 0);
    ram_ctrl_from_hw          = '0;
    ram_ctrl_from_hw[RAM_ACK] = ack_now;
    data_from_hw = pins[RAM_READ_PIN] ? mem_rd(addr) : 32'h0;
  end

  task automatic run_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int n, output logic got_err, output int pin_n);
    logic fin;
    n = 0; pin_n = 0; got_err = 1'b0; fin = 1'b0;
    if (p == 0) begin p0_we = we; p0_addr = a; p0_wdata = d; p0_valid = 1'b1; end
    else        begin p1_we = we; p1_addr = a; p1_wdata = d; p1_valid = 1'b1; end
    while (!fin && n < 200) begin
      @(negedge clk);
      n++;
      if (pin_n == 0 && ram_ctrl_to_hw != 0) pin_n = n;
      if (p == 0) begin fin = p0_done | p0_err; got_err = p0_err; end
      else        begin fin = p1_done | p1_err; got_err = p1_err; end
    end
    if (!fin) chk("req_wait_expired", 0, 1);
    if (p == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0, n1, pn0, pn1, c0;
    logic e0, e1;
    ram_ctrl_from_hw = '0;
    data_from_hw     = '0;
    mem[32'h20]      = 32'h1234;
    rst = 1'b1;
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hCAFE;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h20; p1_wdata = 32'h0;

    // Reset held with both requests pending: outputs stay zero.
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctrl", ram_ctrl_to_hw, 0);
    end
    chk("reset_addr", addr, 0);
    chk("reset_dth", data_to_hw, 0);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
    chk("reset_pulses", {p0_done, p1_done, p0_err, p1_err}, 0);

    // Port 0 write wins first, then port 1 read.
    push(0, 1'b1, 32'h10, 32'hCAFE, 1'b0);
    push(1, 1'b0, 32'h20, 32'h0, 1'b0);
    rst = 1'b0;
    fork
      run_req(0, 1'b1, 32'h10, 32'hCAFE, n0, e0, pn0);
      run_req(1, 1'b0, 32'h20, 32'h0, n1, e1, pn1);
    join
    chk("first_pin_edge", pn0, 2);
    chk("first_done_latency", n0 - 1, 5);
    chk("first_no_err", {e0, e1}, 0);
    chk("p1_read_value", p1_rdata, 32'h1234);
    chk("p0_rdata_untouched", p0_rdata, 0);

    // Continuous contention: grants must alternate 0,1,0,1...
    c0 = n_cmpl;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 32'h100 + i, 32'hA000 + i, 1'b0);
      push(1, 1'b0, 32'h100 + i, 32'h0, 1'b0);
    end
    fork
      for (int i = 0; i < 4; i++) run_req(0, 1'b1, 32'h100 + i, 32'hA000 + i, n0, e0, pn0);
      for (int j = 0; j < 4; j++) run_req(1, 1'b0, 32'h100 + j, 32'h0, n1, e1, pn1);
    join
    chk("burst_completions", n_cmpl - c0, 8);
    chk("burst_last_read", p1_rdata, 32'hA003);

    // ACK stuck high from before the request: no pin until it releases.
    ack_force = 1'b1;
    @(negedge clk);
    push(0, 1'b0, 32'h10, 32'h0, 1'b0);
    fork
      run_req(0, 1'b0, 32'h10, 32'h0, n0, e0, pn0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("hold_no_pin", ram_ctrl_to_hw, 0);
        end
        ack_force = 1'b0;
      end
    join
    chk("hold_no_err", e0, 0);
    chk("hold_read_value", p0_rdata, 32'hCAFE);

    // Dead chip: err after TIMEOUT cycles in WAIT_ACK, rdata kept.
    ack_never = 1'b1;
    @(negedge clk);
    push(0, 1'b0, 32'h20, 32'h0, 1'b1);
    run_req(0, 1'b0, 32'h20, 32'h0, n0, e0, pn0);
    chk("timeout_err", e0, 1);
    chk("timeout_edge", n0, 10);
    chk("timeout_ctrl_clear", ram_ctrl_to_hw, 0);
    chk("timeout_rdata_kept", p0_rdata, 32'hCAFE);
    ack_never = 1'b0;
    @(negedge clk);
    push(0, 1'b1, 32'h30, 32'hBEEF, 1'b0);
    run_req(0, 1'b1, 32'h30, 32'hBEEF, n0, e0, pn0);
    chk("after_timeout_ok", e0, 0);
    chk("after_timeout_latency", n0 - 1, 5);

    // Reset asserted in WAIT_ACK clears outputs without waiting for a clock.
    ack_never = 1'b1;
    @(negedge clk);
    push(1, 1'b1, 32'h40, 32'h55, 1'b0);
    p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h55; p1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_pin_write", ram_ctrl_to_hw, 32'h1 << RAM_WRITE_PIN);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", ram_ctrl_to_hw, 0);
    chk("async_rst_addr_data", {addr, data_to_hw}, 0);
    chk("async_rst_rdata", {p0_rdata, p1_rdata}, 0);
    p1_valid  = 1'b0;
    ack_never = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(0, 1'b0, 32'h20, 32'h0, 1'b0);
    run_req(0, 1'b0, 32'h20, 32'h0, n0, e0, pn0);
    chk("post_reset_read", p0_rdata, 32'h1234);
    chk("post_reset_first_pin", pn0, 2);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_issue.size(), 0);
    chk("no_inflight", inflight_v, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
